// File: rtl/acc_pkg.sv
// acc_pkg: shared types and helpers for the nibble-serial accumulator
//   state_t  : sequencer states
//   NIB_W    : datapath slice width (one adder nibble)
//   k_width(): step-counter width for a given nibble count, never below 1
package acc_pkg;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    localparam int NIB_W = 4;
    function automatic int k_width(input int nstep);
        return (nstep > 1) ? $clog2(nstep) : 1;
    endfunction
endpackage

// File: rtl/fa4_mbit.sv
// fa4_mbit: 4-bit ripple-carry adder
//   a, b : addend nibbles     ci : carry in
//   s    : sum nibble         co : carry out
module fa4_mbit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] w_c;
    assign w_c[0] = ci;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
    assign co = w_c[4];
endmodule

// File: rtl/acc_nibble_serial.sv
// acc_nibble_serial: unsigned accumulator that adds a 4-bit operand one nibble per cycle
//   clk, rst_n (async, active-low)   clr : clear acc/ovf while idle
//   in_valid/in_data/in_ready : operand handshake (operand zero-extended)
//   acc, ovf (sticky carry-out)      out_valid : one-cycle result pulse
//   busy : high while adding or reporting
module acc_nibble_serial
    import acc_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc,
    output logic             ovf,
    output logic             out_valid,
    output logic             busy
);
    localparam int NSTEP = ACC_W / NIB_W;
    localparam int KW    = k_width(NSTEP);

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_op;
    logic [KW-1:0]    r_k;
    logic             r_cy;
    logic             r_ovf;
    logic             r_out_valid;
    logic [KW+1:0]    w_idx;
    logic [3:0]       w_s;
    logic             w_co;

    // bit offset of the nibble handled in the current step
    assign w_idx = {r_k, 2'b00};

    fa4_mbit u_fa (
        .a  (r_acc[w_idx +: NIB_W]),
        .b  (r_op[w_idx +: NIB_W]),
        .ci (r_cy),
        .s  (w_s),
        .co (w_co)
    );

    assign in_ready  = (r_state == IDLE) && !clr;
    assign busy      = (r_state != IDLE);
    assign acc       = r_acc;
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_op        <= '0;
            r_k         <= '0;
            r_cy        <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clr) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                    end else if (in_valid) begin
                        r_op    <= {{(ACC_W-NIB_W){1'b0}}, in_data};
                        r_k     <= '0;
                        r_cy    <= 1'b0;
                        r_state <= ADD;
                    end
                end
                ADD: begin
                    r_acc[w_idx +: NIB_W] <= w_s;
                    r_cy                  <= w_co;
                    if (r_k == KW'(NSTEP-1)) begin
                        r_ovf       <= r_ovf | w_co;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                DONE: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_nibble_serial.sv
// tb_acc_nibble_serial: self-checking bench for acc_nibble_serial (ACC_W = 8)
module tb_acc_nibble_serial;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic         in_valid = 1'b0;
    logic [3:0]   in_data = '0;
    logic         in_ready;
    logic [W-1:0] acc;
    logic         ovf;
    logic         out_valid;
    logic         busy;

    acc_nibble_serial #(.ACC_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .acc(acc), .ovf(ovf), .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {logic [W-1:0] acc; logic ovf; int t;} exp_t;
    typedef struct {logic [3:0] d; logic [W-1:0] acc; logic ovf;} vec_t;

    int       n_tests = 0;
    int       n_fail = 0;
    int       cyc = 0;
    int       n_done = 0;
    exp_t     sb[$];
    int       acc_t[$];
    logic [W-1:0] m_acc = '0;
    logic     m_ovf = 1'b0;
    logic     prev_ov = 1'b0;
    vec_t     v[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: updated on every accepted operand, result queued for the output monitor
    always @(posedge clk) begin
        logic [W:0] s;
        cyc++;
        if (rst_n && !busy && clr) begin
            m_acc = '0;
            m_ovf = 1'b0;
        end else if (rst_n && in_valid && in_ready) begin
            s = m_acc + in_data;
            m_acc = s[W-1:0];
            m_ovf = m_ovf | s[W];
            sb.push_back('{m_acc, m_ovf, cyc});
            acc_t.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            n_done++;
            if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
            else begin
                e = sb.pop_front();
                chk("sb_acc", acc, e.acc);
                chk("sb_ovf", ovf, e.ovf);
                chk("latency", cyc - e.t, 2);
            end
        end
        if (prev_ov) chk("out_valid_pulse", out_valid, 0);
        prev_ov = out_valid;
    end

    task automatic wait_done(input int n);
        for (int i = 0; i < 20 && n_done == n; i++) @(negedge clk);
        chk("done_timeout", n_done != n, 1);
        @(negedge clk);
    endtask

    task automatic do_op(input logic [3:0] d);
        int n;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        chk("ready_timeout", in_ready, 1);
        n = n_done;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        wait_done(n);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        v[0] = '{4'h5, 8'h05, 1'b0};
        v[1] = '{4'h3, 8'h08, 1'b0};
        v[2] = '{4'h7, 8'h0F, 1'b0};
        v[3] = '{4'h1, 8'h10, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_acc", acc, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            do_op(v[i].d);
            chk("vec_acc", acc, v[i].acc);
            chk("vec_ovf", ovf, v[i].ovf);
            chk("vec_idle", busy, 0);
        end

        do_clr();
        chk("clr_acc", acc, 0);
        for (int i = 1; i <= 17; i++) do_op(4'hF);
        chk("wrap17_acc", acc, 8'hFF);
        chk("wrap17_ovf", ovf, 0);
        do_op(4'hF);
        chk("wrap18_acc", acc, 8'h0E);
        chk("wrap18_ovf", ovf, 1);
        do_op(4'h1);
        chk("sticky_acc", acc, 8'h0F);
        chk("sticky_ovf", ovf, 1);

        // clr and in_valid together: clear wins, operand taken the next cycle
        @(negedge clk);
        clr = 1'b1;
        in_valid = 1'b1;
        in_data = 4'h9;
        #1 chk("clr_in_ready", in_ready, 0);
        @(negedge clk);
        chk("clrp_acc", acc, 0);
        chk("clrp_ovf", ovf, 0);
        chk("clrp_busy", busy, 0);
        clr = 1'b0;
        #1 chk("clrp_ready_after", in_ready, 1);
        base = n_done;
        @(negedge clk);
        in_valid = 1'b0;
        chk("clrp_accepted", busy, 1);
        wait_done(base);
        chk("clrp_result", acc, 8'h09);

        // back-to-back accepts with in_valid held high
        do_clr();
        base = acc_t.size();
        in_valid = 1'b1;
        in_data = 4'h2;
        for (int i = 0; i < 30 && acc_t.size() < base + 3; i++) @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_count", acc_t.size() >= base + 3, 1);
        if (acc_t.size() >= base + 3) begin
            chk("b2b_gap1", acc_t[base+1] - acc_t[base], 4);
            chk("b2b_gap2", acc_t[base+2] - acc_t[base+1], 4);
        end
        repeat (6) @(negedge clk);
        chk("b2b_acc", acc, 8'h06);

        // asynchronous reset while adding
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 4'h7;
        @(negedge clk);
        in_valid = 1'b0;
        chk("midrst_busy", busy, 1);
        #1 rst_n = 1'b0;
        sb.delete();
        m_acc = '0;
        m_ovf = 1'b0;
        #1;
        chk("midrst_acc", acc, 0);
        chk("midrst_busy_clr", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_ready", in_ready, 1);
        do_op(4'h3);
        chk("midrst_resume", acc, 8'h03);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
